// File: rtl/ysyx_22041752_fetch_queue.sv
// ysyx_22041752_fetch_queue: multi-outstanding instruction fetch with a prefetch queue;
// redirects clear the queue and discard responses to requests issued before them.
module ysyx_22041752_fetch_queue #(
    parameter int PC_WD = 32,
    parameter int INST_WD = 32,
    parameter int DATA_WD = 64,
    parameter int FQ_DEPTH = 4,
    parameter int MAX_OUTST = 2,
    parameter logic [PC_WD-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     req_valid,
    input  logic                     req_ready,
    output logic [PC_WD-1:0]         req_addr,
    input  logic                     resp_valid,
    input  logic [DATA_WD-1:0]       resp_data,
    input  logic                     flush,
    input  logic [PC_WD-1:0]         flush_pc,
    input  logic                     br_taken,
    input  logic [PC_WD-1:0]         br_target,
    input  logic                     ds_allowin,
    output logic                     fs_to_ds_valid,
    output logic [INST_WD+PC_WD-1:0] fs_to_ds_bus
);
    localparam int QW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int IW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;

    logic [PC_WD-1:0]   fetch_pc;
    logic [CW-1:0]      inflight, drop, qcount, qcount_eff;
    logic [QW-1:0]      rd_ptr, wr_ptr;
    logic [IW-1:0]      ipc_rd, ipc_wr;
    logic [PC_WD-1:0]   q_pc [FQ_DEPTH];
    logic [INST_WD-1:0] q_inst [FQ_DEPTH];
    logic [PC_WD-1:0]   ipc [MAX_OUTST];
    logic               redir, req_fire, resp_ok, enq, deq;
    logic [PC_WD-1:0]   target, resp_pc;
    logic [INST_WD-1:0] resp_inst;

    always_comb begin
        redir = flush | br_taken;
        target = flush ? flush_pc : br_target;
        req_addr = redir ? target : fetch_pc;
        qcount_eff = redir ? '0 : qcount;
        req_valid = ~reset & (inflight < CW'(MAX_OUTST))
                  & ({1'b0, inflight} + {1'b0, qcount_eff} < SW'(FQ_DEPTH));
        req_fire = req_valid & req_ready;
        // a response with nothing outstanding is a protocol error and is ignored
        resp_ok = resp_valid & (inflight != '0);
        resp_pc = ipc[ipc_rd];
        resp_inst = (DATA_WD == 2 * INST_WD && resp_pc[2]) ? resp_data[DATA_WD-1 -: INST_WD]
                                                           : resp_data[INST_WD-1:0];
        enq = resp_ok & (drop == '0) & ~redir;
        fs_to_ds_valid = (qcount != '0) & ~redir;
        deq = fs_to_ds_valid & ds_allowin;
        fs_to_ds_bus = {q_inst[rd_ptr], q_pc[rd_ptr]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            inflight <= '0;
            drop <= '0;
            qcount <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            ipc_rd <= '0;
            ipc_wr <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                q_pc[i] <= '0;
                q_inst[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTST; i++) ipc[i] <= '0;
        end else begin
            fetch_pc <= req_fire ? req_addr + PC_WD'(4) : redir ? target : fetch_pc;
            inflight <= inflight + CW'(req_fire) - CW'(resp_ok);
            // on redirect every request issued before this cycle becomes stale
            drop <= redir ? inflight - CW'(resp_ok) : drop - CW'(resp_ok & (drop != '0));
            if (req_fire) begin
                ipc[ipc_wr] <= req_addr;
                ipc_wr <= (ipc_wr == IW'(MAX_OUTST - 1)) ? '0 : ipc_wr + IW'(1);
            end
            if (resp_ok) ipc_rd <= (ipc_rd == IW'(MAX_OUTST - 1)) ? '0 : ipc_rd + IW'(1);
            if (enq) begin
                q_pc[wr_ptr] <= resp_pc;
                q_inst[wr_ptr] <= resp_inst;
            end
            rd_ptr <= redir ? '0 : rd_ptr + QW'(deq);
            wr_ptr <= redir ? '0 : wr_ptr + QW'(enq);
            qcount <= redir ? '0 : qcount + CW'(enq) - CW'(deq);
        end
    end
endmodule

// File: tb/tb_ysyx_22041752_fetch_queue.sv
// tb_ysyx_22041752_fetch_queue: directed scenarios plus random traffic checked against an
// epoch-tagged model (each redirect starts a new epoch; responses from older epochs are dropped).
module tb_ysyx_22041752_fetch_queue;
    localparam int FQ_DEPTH = 4;
    localparam int MAX_OUTST = 2;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, fs_to_ds_valid;
    logic        req_ready = 1'b0, resp_valid = 1'b0, flush = 1'b0, br_taken = 1'b0, ds_allowin = 1'b0;
    logic [31:0] req_addr;
    logic [31:0] flush_pc = '0, br_target = '0;
    logic [63:0] resp_data = '0;
    logic [63:0] fs_to_ds_bus;

    ysyx_22041752_fetch_queue #(
        .PC_WD(32), .INST_WD(32), .DATA_WD(64), .FQ_DEPTH(FQ_DEPTH),
        .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .flush(flush), .flush_pc(flush_pc), .br_taken(br_taken), .br_target(br_target),
        .ds_allowin(ds_allowin), .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        pend[$];
    ent_t        fq[$];
    logic [31:0] m_pc;
    int          epoch;
    int          n_checks = 0, n_pass = 0;
    logic        e_rv, e_fv, e_rd;
    logic [31:0] e_addr, e_tgt;
    bit          found;

    function automatic logic [63:0] mem_data(input logic [31:0] pc);
        return {pc ^ 32'hdead_beef, pc ^ 32'h1234_5678};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic m_reset();
        pend.delete();
        fq.delete();
        m_pc = RESET_PC;
        epoch = 0;
    endtask

    task automatic drive_resp(input bit v);
        resp_valid = v && pend.size() != 0;
        resp_data = pend.size() != 0 ? mem_data(pend[0].pc) : {$urandom, $urandom};
    endtask

    task automatic sample();
        int cnt;
        #1;
        e_rd = flush | br_taken;
        e_tgt = flush ? flush_pc : br_target;
        e_addr = e_rd ? e_tgt : m_pc;
        cnt = e_rd ? 0 : fq.size();
        e_rv = !reset && pend.size() < MAX_OUTST && pend.size() + cnt < FQ_DEPTH;
        e_fv = fq.size() != 0 && !e_rd;
        chk("req_valid", req_valid, e_rv);
        chk("req_addr", req_addr, e_addr);
        chk("fs_valid", fs_to_ds_valid, e_fv);
        if (e_fv) chk("fs_bus", fs_to_ds_bus, {fq[0].inst, fq[0].pc});
    endtask

    task automatic advance();
        req_t r;
        @(posedge clk);
        if (!reset) begin
            if (e_fv && ds_allowin) void'(fq.pop_front());
            if (resp_valid && pend.size() != 0) begin
                r = pend.pop_front();
                if (r.epoch == epoch && !e_rd)
                    fq.push_back('{pc: r.pc, inst: r.pc[2] ? resp_data[63:32] : resp_data[31:0]});
            end
            if (e_rd) begin
                fq.delete();
                epoch++;
            end
            if (e_rv && req_ready) begin
                pend.push_back('{pc: e_addr, epoch: epoch});
                m_pc = e_addr + 32'd4;
            end else if (e_rd) m_pc = e_tgt;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {req_ready, resp_valid, flush, br_taken, ds_allowin} = '0;
        m_reset();
        sample();
        advance();
        reset = 1'b0;
    endtask

    task automatic redirect_case(input string tag, input bit fl, input logic [31:0] exp_tgt);
        do_reset();
        ds_allowin = 1'b1;
        req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_resp(1'b0);
            sample();
            chk({tag, "_pre_addr"}, req_addr, RESET_PC + 32'(4 * i));
            advance();
        end
        flush = fl;
        flush_pc = 32'h8000_0200;
        br_taken = 1'b1;
        br_target = fl ? 32'h8000_0300 : 32'h8000_0100;
        drive_resp(1'b0);
        sample();
        chk({tag, "_redir_addr"}, req_addr, exp_tgt);
        chk({tag, "_redir_fsv"}, fs_to_ds_valid, 1'b0);
        advance();
        {flush, br_taken} = '0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive_resp(1'b1);
            sample();
            if (fs_to_ds_valid) begin
                found = 1'b1;
                chk({tag, "_first_pc"}, fs_to_ds_bus[31:0], exp_tgt);
            end
            advance();
        end
        chk({tag, "_seen"}, found, 1'b1);
    endtask

    task automatic rand_inputs();
        req_ready = $urandom_range(0, 9) < 7;
        drive_resp($urandom_range(0, 9) < 6);
        if (pend.size() == 0 && $urandom_range(0, 19) == 0) resp_valid = 1'b1;
        ds_allowin = $urandom_range(0, 9) < 7;
        flush = $urandom_range(0, 49) == 0;
        br_taken = $urandom_range(0, 19) == 0;
        flush_pc = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
        br_target = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
    endtask

    initial begin
        m_reset();
        @(negedge clk);
        sample();
        chk("rst_bus", fs_to_ds_bus, 64'h0);
        advance();
        reset = 1'b0;
        // streaming, one-cycle response latency; first two responses carry the split-word vector
        ds_allowin = 1'b1;
        req_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive_resp(1'b1);
            if (k == 1 || k == 2) resp_data = 64'h1111_1111_2222_2222;
            sample();
            if (k == 0) chk("first_req", {req_valid, req_addr}, {1'b1, RESET_PC});
            if (k >= 2) chk("stream_pc", {fs_to_ds_valid, fs_to_ds_bus[31:0]}, {1'b1, RESET_PC + 32'(4 * (k - 2))});
            if (k == 2) chk("inst_lo", fs_to_ds_bus[63:32], 32'h2222_2222);
            if (k == 3) chk("inst_hi", fs_to_ds_bus[63:32], 32'h1111_1111);
            advance();
        end
        // decode stalled: queue fills, requests stop, nothing lost on drain
        ds_allowin = 1'b0;
        for (int k = 0; k < 8; k++) begin
            drive_resp(1'b1);
            sample();
            if (k == 7) chk("full_stall", {req_valid, fs_to_ds_valid}, 2'b01);
            advance();
        end
        ds_allowin = 1'b1;
        req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_resp(1'b1);
            sample();
            chk("drain_valid", fs_to_ds_valid, k < 4);
            advance();
        end
        redirect_case("br", 1'b0, 32'h8000_0100);
        redirect_case("flush_br", 1'b1, 32'h8000_0200);
        // asynchronous reset with work in flight and queued
        do_reset();
        req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_resp(1'b1);
            sample();
            advance();
        end
        reset = 1'b1;
        #1;
        chk("async_rst_out", {req_valid, fs_to_ds_valid, req_addr}, {2'b00, RESET_PC});
        chk("async_rst_bus", fs_to_ds_bus, 64'h0);
        m_reset();
        advance();
        reset = 1'b0;
        req_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            resp_valid = 1'b1;
            resp_data = {$urandom, $urandom};
            sample();
            chk("late_resp_fsv", fs_to_ds_valid, 1'b0);
            advance();
        end
        resp_valid = 1'b0;
        req_ready = 1'b1;
        sample();
        chk("post_rst_req", {req_valid, req_addr}, {1'b1, RESET_PC});
        advance();
        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            sample();
            advance();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
